// File: rtl/ram_sp_req_ctrl_if.sv
// Request/response handshake bundle between a requester and the single-port RAM front-end.
// The master drives requests and consumes responses; the slave is the controller.
`timescale 1ns/1ps
interface ram_sp_req_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
);
    localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [STRB_WIDTH-1:0] req_wstrb;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram_sp_req_ctrl.sv
// Valid/ready front-end for a single-port bitmask RAM: drives the RAM ports directly from the
// accepted request and buffers 1-cycle read data in a 2-entry response FIFO.
`timescale 1ns/1ps
module ram_sp_req_ctrl #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clock,
    input  logic                  reset,
    ram_sp_req_ctrl_if.slave      bus,
    output logic                  ram_cen,
    output logic                  ram_wen,
    output logic [DATA_WIDTH-1:0] ram_bwen,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  in_range;
    logic                  acc;
    logic                  acc_rd;
    logic                  pop;
    logic                  push;
    logic [2:0]            occupancy;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  req_ready;

    logic [1:0]            count_q,   count_d;
    logic                  rd_ptr_q,  rd_ptr_d;
    logic                  wr_ptr_q,  wr_ptr_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_oor_q,  rd_oor_d;
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];

    // A read may only be accepted if its response is guaranteed a FIFO slot, counting the
    // read already in flight and any slot freed by a pop this same cycle.
    always_comb begin
        in_range  = ({1'b0, bus.req_addr} < DEPTH_L);
        pop       = bus.rsp_valid & bus.rsp_ready;
        occupancy = {1'b0, count_q} + {2'b00, rd_pend_q} - {2'b00, pop};
        if (reset) begin
            req_ready = 1'b0;
        end else if (bus.req_write) begin
            req_ready = 1'b1;
        end else begin
            req_ready = (occupancy < 3'd2);
        end
        acc      = bus.req_valid & req_ready;
        acc_rd   = acc & ~bus.req_write;
        ram_cen  = acc & in_range;
        ram_wen  = bus.req_write;
        ram_addr = bus.req_addr;
        ram_din  = bus.req_wdata;
        ram_bwen = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            ram_bwen[8*i +: 8] = {8{bus.req_wstrb[i]}};
        end

        push      = rd_pend_q;
        push_data = rd_oor_q ? '0 : ram_dout;
        rd_pend_d = acc_rd;
        rd_oor_d  = acc_rd & ~in_range;
        mem_d     = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + 2'(push) - 2'(pop);
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (count_q != 2'd0);
    assign bus.rsp_rdata = mem_q[rd_ptr_q];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q   <= 2'd0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_oor_q  <= 1'b0;
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
        end else begin
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_pend_q <= rd_pend_d;
            rd_oor_q  <= rd_oor_d;
            mem_q[0]  <= mem_d[0];
            mem_q[1]  <= mem_d[1];
        end
    end
endmodule

// File: tb/tb_ram_sp_req_ctrl.sv
// Directed bench for ram_sp_req_ctrl with DEPTH=12, driving a behavioural bitmask RAM so that
// addresses 12..15 are out of range.
`timescale 1ns/1ps
module tb_ram_sp_req_ctrl;
    localparam int DW = 32;
    localparam int DEPTH = 12;
    localparam int AW = 4;

    logic          clock;
    logic          reset;
    logic          ram_cen;
    logic          ram_wen;
    logic [DW-1:0] ram_bwen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] ram_mem [DEPTH];

    int total = 0;
    int bad   = 0;

    ram_sp_req_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    ram_sp_req_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .ram_cen  (ram_cen),
        .ram_wen  (ram_wen),
        .ram_bwen (ram_bwen),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port RAM: dout only changes on read cycles, writes merge under the bit mask.
    always @(posedge clock) begin
        if (ram_cen) begin
            if (ram_wen) begin
                ram_mem[ram_addr] <= (ram_mem[ram_addr] & ~ram_bwen) | (ram_din & ram_bwen);
            end else begin
                ram_dout <= ram_mem[ram_addr];
            end
        end
    end

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic drive_req(input logic valid, input logic wr, input logic [AW-1:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        bus.req_valid = valid;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wstrb = s;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic exp_cen);
        @(negedge clock);
        drive_req(1'b1, 1'b1, a, d, s);
        #1;
        check_output("wr_ready", bus.req_ready, 1);
        check_output("wr_cen", ram_cen, exp_cen);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic read_single(input logic [AW-1:0] a, input logic [31:0] exp_data);
        @(negedge clock);
        drive_req(1'b1, 1'b0, a, 32'h0, 4'h0);
        #1;
        check_output("rd_ready", bus.req_ready, 1);
        check_output("rd_cen", ram_cen, ({1'b0, a} < 5'd12));
        check_output("rd_wen", ram_wen, 0);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        check_output("rd_lat1_valid", bus.rsp_valid, 0);
        @(negedge clock);
        check_output("rd_lat2_valid", bus.rsp_valid, 1);
        check_output("rd_data", bus.rsp_rdata, exp_data);
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
        ram_dout      = '0;
        bus.rsp_ready = 1'b1;
        drive_req(1'b1, 1'b1, 4'd0, 32'h0, 4'h0);
        reset = 1'b1;
        #2;
        check_output("rst_req_ready", bus.req_ready, 0);
        check_output("rst_rsp_valid", bus.rsp_valid, 0);
        check_output("rst_rsp_rdata", bus.rsp_rdata, 0);
        bus.req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Full write then readback, then partial strobes merge into the old word.
        do_write(4'd3, 32'hDEADBEEF, 4'hF, 1'b1);
        read_single(4'd3, 32'hDEADBEEF);
        @(negedge clock);
        drive_req(1'b1, 1'b1, 4'd3, 32'h11223344, 4'b0101);
        #1;
        check_output("bwen_0101", ram_bwen, 32'h00FF00FF);
        check_output("din_pass", ram_din, 32'h11223344);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        read_single(4'd3, 32'hDE22BE44);

        // Backpressure: only two reads fit, writes still pass, responses drain in order.
        do_write(4'd0, 32'hA0A0A0A0, 4'hF, 1'b1);
        do_write(4'd1, 32'hB1B1B1B1, 4'hF, 1'b1);
        do_write(4'd2, 32'hC2C2C2C2, 4'hF, 1'b1);
        bus.rsp_ready = 1'b0;
        @(negedge clock);
        drive_req(1'b1, 1'b0, 4'd0, 32'h0, 4'h0);
        #1;
        check_output("bp_rd0_ready", bus.req_ready, 1);
        @(negedge clock);
        drive_req(1'b1, 1'b0, 4'd1, 32'h0, 4'h0);
        #1;
        check_output("bp_rd1_ready", bus.req_ready, 1);
        @(negedge clock);
        drive_req(1'b1, 1'b0, 4'd2, 32'h0, 4'h0);
        #1;
        check_output("bp_rd2_blocked", bus.req_ready, 0);
        check_output("bp_rd2_cen", ram_cen, 0);
        @(negedge clock);
        check_output("bp_full_blocked", bus.req_ready, 0);
        check_output("bp_head_valid", bus.rsp_valid, 1);
        check_output("bp_head_stable", bus.rsp_rdata, 32'hA0A0A0A0);
        @(negedge clock);
        drive_req(1'b1, 1'b1, 4'd5, 32'h5555AAAA, 4'hF);
        #1;
        check_output("bp_wr_ready", bus.req_ready, 1);
        check_output("bp_wr_cen", ram_cen, 1);
        @(negedge clock);
        drive_req(1'b1, 1'b0, 4'd2, 32'h0, 4'h0);
        bus.rsp_ready = 1'b1;
        #1;
        check_output("bp_rd2_ready", bus.req_ready, 1);
        check_output("bp_rsp0", bus.rsp_rdata, 32'hA0A0A0A0);
        @(negedge clock);
        drive_req(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
        #1;
        check_output("bp_rd3_ready", bus.req_ready, 1);
        check_output("bp_rsp1", bus.rsp_rdata, 32'hB1B1B1B1);
        @(negedge clock);
        bus.req_valid = 1'b0;
        #1;
        check_output("bp_rsp2_valid", bus.rsp_valid, 1);
        check_output("bp_rsp2", bus.rsp_rdata, 32'hC2C2C2C2);
        @(negedge clock);
        check_output("bp_rsp3", bus.rsp_rdata, 32'hDE22BE44);
        @(negedge clock);
        check_output("bp_drained", bus.rsp_valid, 0);

        // Streaming reads: one response per cycle, out-of-range slots return zero.
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), pat(i), 4'hF, 1'b1);
        for (int c = 0; c < 18; c++) begin
            @(negedge clock);
            if (c < 16) drive_req(1'b1, 1'b0, AW'(c), 32'h0, 4'h0);
            else        bus.req_valid = 1'b0;
            #1;
            if (c < 16) begin
                check_output("bb_ready", bus.req_ready, 1);
                check_output("bb_cen", ram_cen, (c < DEPTH));
            end
            if (c >= 2) begin
                check_output("bb_valid", bus.rsp_valid, 1);
                check_output("bb_data", bus.rsp_rdata, (c - 2 < DEPTH) ? pat(c - 2) : 32'h0);
            end
        end
        @(negedge clock);
        check_output("bb_drained", bus.rsp_valid, 0);

        // Out-of-range write is dropped and leaves the RAM untouched.
        do_write(4'd13, 32'hFFFFFFFF, 4'hF, 1'b0);
        read_single(4'd13, 32'h0);
        read_single(4'd1, pat(1));

        // Reset with one response buffered and one read in flight.
        bus.rsp_ready = 1'b0;
        @(negedge clock);
        drive_req(1'b1, 1'b0, 4'd0, 32'h0, 4'h0);
        @(negedge clock);
        drive_req(1'b1, 1'b0, 4'd1, 32'h0, 4'h0);
        @(negedge clock);
        drive_req(1'b1, 1'b1, 4'd0, 32'h0, 4'h0);
        #1;
        check_output("mid_rsp_valid", bus.rsp_valid, 1);
        reset = 1'b1;
        #1;
        check_output("mid_rst_rsp_valid", bus.rsp_valid, 0);
        check_output("mid_rst_req_ready", bus.req_ready, 0);
        bus.req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check_output("post_rst_no_rsp", bus.rsp_valid, 0);
        end
        read_single(4'd2, pat(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
